// File: rtl/sr_block_sequencer.sv
// Block sequencer for a separable sub-pel filter: issues per-block config tokens,
// forwards the extended input pel window and counts filter results until done.
module sr_block_sequencer #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TAP     = 8,
   parameter int unsigned SIZE_W  = 7,
   parameter int unsigned ALPHA_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   // block command
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [SIZE_W-1:0]  cmd_size,
   input  logic [ALPHA_W-1:0] cmd_v_alpha,
   input  logic [ALPHA_W-1:0] cmd_h_alpha,
   // config tokens to the filter
   output logic [ALPHA_W-1:0] v_alpha_din,
   output logic [ALPHA_W-1:0] h_alpha_din,
   output logic [SIZE_W-1:0]  ext_size_din,
   output logic               v_alpha_write,
   output logic               h_alpha_write,
   output logic               ext_size_write,
   input  logic               v_alpha_full,
   input  logic               h_alpha_full,
   input  logic               ext_size_full,
   // upstream pel port
   input  logic [DATA_W-1:0]  pel_in_din,
   input  logic               pel_in_write,
   output logic               pel_in_full,
   // pel port to the filter
   output logic [DATA_W-1:0]  pel_out_din,
   output logic               pel_out_write,
   input  logic               pel_out_full,
   // filter result monitor and status
   input  logic               res_write,
   output logic               done,
   output logic               err
);

   localparam int unsigned CNT_W = 2 * SIZE_W;

   typedef enum logic [2:0] {StIdle, StCfg, StStream, StDrain, StDone} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  in_total_q, out_total_q;
   logic [CNT_W-1:0]  in_cnt_q, out_cnt_q;

   logic              cmd_fire, cmd_ok;
   logic [SIZE_W-1:0] ext_nxt;
   logic              v_xfer, h_xfer, x_xfer;
   logic              v_wr_nxt, h_wr_nxt, x_wr_nxt;
   logic              pel_xfer;
   logic              res_window, res_count, res_over;
   logic [CNT_W-1:0]  out_cnt_nxt;

   // Command decode, handshake and result accounting
   always_comb begin
      cmd_ready   = (state_q == StIdle) && !rst;
      cmd_fire    = cmd_valid && cmd_ready;
      cmd_ok      = (cmd_size inside {SIZE_W'(4), SIZE_W'(8), SIZE_W'(16), SIZE_W'(32),
                                      SIZE_W'(64)})
                    && (cmd_v_alpha inside {ALPHA_W'(0), ALPHA_W'(2), ALPHA_W'(4), ALPHA_W'(6)})
                    && (cmd_h_alpha inside {ALPHA_W'(0), ALPHA_W'(2), ALPHA_W'(4), ALPHA_W'(6)});
      ext_nxt     = cmd_size + SIZE_W'(TAP - 1);
      v_xfer      = v_alpha_write && !v_alpha_full;
      h_xfer      = h_alpha_write && !h_alpha_full;
      x_xfer      = ext_size_write && !ext_size_full;
      v_wr_nxt    = v_alpha_write && !v_xfer;
      h_wr_nxt    = h_alpha_write && !h_xfer;
      x_wr_nxt    = ext_size_write && !x_xfer;
      pel_xfer    = (state_q == StStream) && pel_in_write && !pel_out_full;
      res_window  = (state_q == StCfg) || (state_q == StStream) || (state_q == StDrain);
      res_count   = res_write && res_window && (out_cnt_q != out_total_q);
      res_over    = res_write && !res_count;
      out_cnt_nxt = out_cnt_q + CNT_W'(res_count);
   end

   // Zero-latency pel pass-through, closed outside STREAM
   always_comb begin
      pel_out_din   = (state_q == StStream) ? pel_in_din : '0;
      pel_out_write = (state_q == StStream) && pel_in_write;
      pel_in_full   = (state_q == StStream) ? pel_out_full : 1'b1;
   end

   // Block FSM with registered token and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         in_total_q     <= '0;
         out_total_q    <= '0;
         in_cnt_q       <= '0;
         out_cnt_q      <= '0;
         v_alpha_din    <= '0;
         h_alpha_din    <= '0;
         ext_size_din   <= '0;
         v_alpha_write  <= 1'b0;
         h_alpha_write  <= 1'b0;
         ext_size_write <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= res_over;
         out_cnt_q <= out_cnt_nxt;
         unique case (state_q)
            StIdle: begin
               if (cmd_fire) begin
                  if (cmd_ok) begin
                     v_alpha_din    <= cmd_v_alpha;
                     h_alpha_din    <= cmd_h_alpha;
                     ext_size_din   <= ext_nxt;
                     v_alpha_write  <= 1'b1;
                     h_alpha_write  <= 1'b1;
                     ext_size_write <= 1'b1;
                     in_total_q     <= CNT_W'(ext_nxt) * CNT_W'(ext_nxt);
                     out_total_q    <= CNT_W'(cmd_size) * CNT_W'(cmd_size);
                     in_cnt_q       <= '0;
                     out_cnt_q      <= '0;
                     state_q        <= StCfg;
                  end else begin
                     // malformed command is swallowed, only flagged
                     err <= 1'b1;
                  end
               end
            end
            StCfg: begin
               v_alpha_write  <= v_wr_nxt;
               h_alpha_write  <= h_wr_nxt;
               ext_size_write <= x_wr_nxt;
               if (!v_wr_nxt && !h_wr_nxt && !x_wr_nxt) begin
                  state_q <= StStream;
               end
            end
            StStream: begin
               if (pel_xfer) begin
                  in_cnt_q <= in_cnt_q + CNT_W'(1);
                  if (in_cnt_q + CNT_W'(1) == in_total_q) begin
                     state_q <= StDrain;
                  end
               end
            end
            StDrain: begin
               // look at the post-increment count so done follows the last result by one cycle
               if (out_cnt_nxt == out_total_q) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_block_sequencer.sv
// Self-checking bench for sr_block_sequencer: directed vector table, hand-written
// reset-abort sequence and randomized blocks against a block-level reference model.
module tb_sr_block_sequencer;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned TAP     = 8;
   localparam int unsigned SIZE_W  = 7;
   localparam int unsigned ALPHA_W = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               cmd_valid, cmd_ready;
   logic [SIZE_W-1:0]  cmd_size;
   logic [ALPHA_W-1:0] cmd_v_alpha, cmd_h_alpha;
   logic [ALPHA_W-1:0] v_alpha_din, h_alpha_din;
   logic [SIZE_W-1:0]  ext_size_din;
   logic               v_alpha_write, h_alpha_write, ext_size_write;
   logic               v_alpha_full, h_alpha_full, ext_size_full;
   logic [DATA_W-1:0]  pel_in_din, pel_out_din;
   logic               pel_in_write, pel_in_full, pel_out_write, pel_out_full;
   logic               res_write, done, err;

   sr_block_sequencer #(
      .DATA_W (DATA_W),
      .TAP    (TAP),
      .SIZE_W (SIZE_W),
      .ALPHA_W(ALPHA_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_size      (cmd_size),
      .cmd_v_alpha   (cmd_v_alpha),
      .cmd_h_alpha   (cmd_h_alpha),
      .v_alpha_din   (v_alpha_din),
      .h_alpha_din   (h_alpha_din),
      .ext_size_din  (ext_size_din),
      .v_alpha_write (v_alpha_write),
      .h_alpha_write (h_alpha_write),
      .ext_size_write(ext_size_write),
      .v_alpha_full  (v_alpha_full),
      .h_alpha_full  (h_alpha_full),
      .ext_size_full (ext_size_full),
      .pel_in_din    (pel_in_din),
      .pel_in_write  (pel_in_write),
      .pel_in_full   (pel_in_full),
      .pel_out_din   (pel_out_din),
      .pel_out_write (pel_out_write),
      .pel_out_full  (pel_out_full),
      .res_write     (res_write),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // transfer monitor state
   int v_n = 0, h_n = 0, x_n = 0, p_n = 0, u_n = 0;
   int v_cyc = 0, h_cyc = 0, x_cyc = 0, first_pel_cyc = 0, cyc = 0;
   int v_last = 0, h_last = 0, x_last = 0;
   int mirror_bad = 0, done_n = 0, err_n = 0, both_n = 0;
   bit pel_arm = 1'b0;

   // Count transfers at the falling edge, where every input is already settled
   always @(negedge clk) begin
      if (v_alpha_write && !v_alpha_full) begin v_n++; v_last = v_alpha_din; v_cyc = cyc; end
      if (h_alpha_write && !h_alpha_full) begin h_n++; h_last = h_alpha_din; h_cyc = cyc; end
      if (ext_size_write && !ext_size_full) begin x_n++; x_last = ext_size_din; x_cyc = cyc; end
      if (pel_out_write && !pel_out_full) begin
         p_n++;
         if (pel_arm) begin first_pel_cyc = cyc; pel_arm = 1'b0; end
      end
      if (pel_in_write && !pel_in_full) u_n++;
      if (pel_out_write && (pel_in_full != pel_out_full || pel_out_din != pel_in_din)) mirror_bad++;
      if (pel_in_write && !pel_in_full && !pel_out_write) mirror_bad++;
      if (done) done_n++;
      if (err) err_n++;
      if (done && err) both_n++;
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {cmd_ready, writes x3, pel_out_write, pel_in_full, done, err, dins...} in IDLE after reset
   task automatic check_idle(input string tag);
      logic [63:0] act, exp;
      act = {35'd0, cmd_ready, v_alpha_write, h_alpha_write, ext_size_write, pel_out_write,
             pel_in_full, done, err, v_alpha_din, h_alpha_din, ext_size_din, pel_out_din};
      exp = {35'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 7'd0, 8'd0};
      chk({tag, " idle outputs"}, act, exp);
   endtask

   // Reference model: block-level rules only
   function automatic bit ref_valid(input int s, input int va, input int ha);
      return (s == 4 || s == 8 || s == 16 || s == 32 || s == 64) &&
             (va inside {0, 2, 4, 6}) && (ha inside {0, 2, 4, 6});
   endfunction

   // bp: 0 none, 1 toggle, 2 random; early: send all results while streaming
   task automatic run_block(input string tag, input int size, input int va, input int ha,
                            input int hold, input int bp, input bit early, input int extra,
                            input bit e_valid, input int e_ext, input int e_pels,
                            input int e_res);
      int v0, h0, x0, p0, u0, d0, e0, b0, guard, sent, hold_bad;
      v0 = v_n; h0 = h_n; x0 = x_n; p0 = p_n; u0 = u_n; d0 = done_n; e0 = err_n; b0 = mirror_bad;
      sent = 0; hold_bad = 0;
      pel_arm      = 1'b1;
      cmd_valid    = 1'b1;
      cmd_size     = SIZE_W'(size);
      cmd_v_alpha  = ALPHA_W'(va);
      cmd_h_alpha  = ALPHA_W'(ha);
      pel_in_write = 1'b1;
      pel_in_din   = DATA_W'($urandom);
      pel_out_full = 1'b0;
      #1 chk({tag, " cmd_ready before accept"}, cmd_ready, 1);
      step();
      cmd_valid     = 1'b0;
      ext_size_full = (hold > 0);
      if (!e_valid) begin
         #1;
         chk({tag, " err pulse"}, err, 1);
         chk({tag, " cmd_ready stays"}, cmd_ready, 1);
         chk({tag, " no token write"}, {v_alpha_write, h_alpha_write, ext_size_write}, 0);
         pel_in_write = 1'b0;
         step();
         chk({tag, " err single cycle"}, err, 0);
         step();
         chk({tag, " no transfers"}, (v_n - v0) + (h_n - h0) + (x_n - x0) + (p_n - p0), 0);
         chk({tag, " err count"}, err_n - e0, 1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         #1 if (!(ext_size_write && ext_size_din == SIZE_W'(e_ext))) hold_bad++;
         step();
      end
      ext_size_full = 1'b0;
      guard = 0;
      while (p_n - p0 < e_pels && guard < 4 * e_pels + 50) begin
         pel_in_din = DATA_W'($urandom);
         if (bp == 1) pel_out_full = ~pel_out_full;
         else if (bp == 2) pel_out_full = 1'($urandom);
         res_write = early && (sent < e_res);
         if (res_write) sent++;
         step();
         guard++;
      end
      res_write    = 1'b0;
      pel_out_full = 1'b0;
      chk({tag, " pels forwarded"}, p_n - p0, e_pels);
      #1 chk({tag, " extra pel refused"}, pel_in_full, 1);
      if (early) begin
         step();
         #1 chk({tag, " done after one-cycle drain"}, done, 1);
      end else begin
         for (int i = 0; i < e_res; i++) begin
            res_write = 1'b1;
            step();
         end
         res_write = 1'b0;
         #1 chk({tag, " done after last result"}, done, 1);
      end
      pel_in_write = 1'b0;
      step();
      chk({tag, " done single cycle"}, done, 0);
      chk({tag, " back to idle"}, cmd_ready, 1);
      for (int i = 0; i < extra; i++) begin
         res_write = 1'b1;
         step();
      end
      res_write = 1'b0;
      step();
      step();
      chk({tag, " token counts"}, {v_n - v0, h_n - h0, x_n - x0}, {32'd1, 32'd1, 32'd1});
      chk({tag, " token values"}, {v_last, h_last, x_last}, {va, ha, e_ext});
      chk({tag, " ext held stable"}, hold_bad, 0);
      chk({tag, " v/h same edge"}, h_cyc - v_cyc, 0);
      chk({tag, " ext delay"}, x_cyc - v_cyc, hold);
      if (bp == 0) chk({tag, " stream starts after tokens"}, first_pel_cyc - x_cyc, 1);
      else chk({tag, " no pel before tokens"}, first_pel_cyc > x_cyc, 1);
      chk({tag, " upstream pels"}, u_n - u0, e_pels);
      chk({tag, " pel mirror"}, mirror_bad - b0, 0);
      chk({tag, " done count"}, done_n - d0, 1);
      chk({tag, " overflow errs"}, err_n - e0, extra);
   endtask

   typedef struct {
      int size; int va; int ha; int hold; int bp; bit early; int extra;
      bit e_valid; int e_ext; int e_pels; int e_res;
   } vec_t;

   initial begin
      vec_t vecs[8];
      int   sizes[7];
      int   s, va, ha, ext, p0;

      vecs[0] = '{16, 2, 2, 0, 0, 1'b0, 0, 1'b1, 23, 529, 256};
      vecs[1] = '{16, 2, 2, 5, 0, 1'b0, 0, 1'b1, 23, 529, 256};
      vecs[2] = '{4,  0, 6, 0, 1, 1'b0, 0, 1'b1, 11, 121, 16};
      vecs[3] = '{12, 2, 2, 0, 0, 1'b0, 0, 1'b0, 0, 0, 0};
      vecs[4] = '{8,  3, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 0};
      vecs[5] = '{4,  4, 4, 1, 0, 1'b1, 0, 1'b1, 11, 121, 16};
      vecs[6] = '{8,  6, 0, 2, 2, 1'b0, 2, 1'b1, 15, 225, 64};
      vecs[7] = '{32, 0, 0, 0, 2, 1'b0, 1, 1'b1, 39, 1521, 1024};
      sizes   = '{4, 8, 16, 12, 5, 4, 8};

      rst = 1'b1; cmd_valid = 1'b0; cmd_size = '0; cmd_v_alpha = '0; cmd_h_alpha = '0;
      v_alpha_full = 1'b0; h_alpha_full = 1'b0; ext_size_full = 1'b0;
      pel_in_din = '0; pel_in_write = 1'b0; pel_out_full = 1'b0; res_write = 1'b0;
      step();
      chk("cmd_ready low in reset", cmd_ready, 0);
      step();
      rst = 1'b0;
      #1 check_idle("post reset");

      for (int i = 0; i < 8; i++) begin
         run_block($sformatf("vec%0d", i), vecs[i].size, vecs[i].va, vecs[i].ha, vecs[i].hold,
                   vecs[i].bp, vecs[i].early, vecs[i].extra, vecs[i].e_valid, vecs[i].e_ext,
                   vecs[i].e_pels, vecs[i].e_res);
      end

      // abort a size-64 block after 100 pels
      p0 = p_n;
      cmd_valid = 1'b1; cmd_size = 7'd64; cmd_v_alpha = 3'd2; cmd_h_alpha = 3'd4;
      pel_in_write = 1'b1;
      step();
      cmd_valid = 1'b0;
      for (int g = 0; g < 400 && p_n - p0 < 100; g++) begin
         pel_in_din = DATA_W'($urandom);
         step();
      end
      chk("abort pels before reset", p_n - p0, 100);
      rst = 1'b1;
      pel_in_write = 1'b0;
      #1 chk("abort cmd_ready in reset", cmd_ready, 0);
      step();
      rst = 1'b0;
      #1 check_idle("after abort");
      step();
      run_block("after abort", 8, 0, 2, 0, 0, 1'b0, 0, 1'b1, 15, 225, 64);

      // randomized blocks against the reference model
      for (int r = 0; r < 6; r++) begin
         s   = sizes[$urandom_range(0, 6)];
         va  = ($urandom_range(0, 4) == 0) ? 3 : 2 * $urandom_range(0, 3);
         ha  = ($urandom_range(0, 4) == 0) ? 5 : 2 * $urandom_range(0, 3);
         ext = s + TAP - 1;
         run_block($sformatf("rand%0d", r), s, va, ha, $urandom_range(0, 3),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   ref_valid(s, va, ha), ext, ext * ext, s * s);
      end

      chk("err and done never together", both_n, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
